// File: rtl/ft232h_cmd_parser.sv
// Frame decoder for the FT232H byte stream: sync hunt, cmd/len/payload extraction,
// 8-bit additive checksum verification and inter-byte timeout.
module ft232h_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte,
  output logic [7:0] o_cmd,
  output logic [7:0] o_len,
  output logic       o_pl_valid,
  output logic [7:0] o_pl_data,
  output logic [7:0] o_pl_idx,
  output logic       o_frame_done,
  output logic       o_frame_ok,
  output logic [1:0] o_err_code,
  output logic       o_busy
);

  typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CHK} state_t;

  localparam logic [19:0] GAP_TC = 20'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  MAX_L  = 8'(MAX_LEN);

  state_t      state;
  logic [7:0]  sum;
  logic [7:0]  idx;
  logic [19:0] gap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= HUNT;
      sum          <= '0;
      idx          <= '0;
      gap          <= '0;
      o_cmd        <= '0;
      o_len        <= '0;
      o_pl_valid   <= 1'b0;
      o_pl_data    <= '0;
      o_pl_idx     <= '0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_err_code   <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_pl_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      // A byte always wins over the timeout terminal count in the same cycle.
      if (i_byte_valid) begin
        gap <= '0;
        unique case (state)
          HUNT: begin
            if (i_byte == SYNC_BYTE) begin
              state  <= CMD;
              o_busy <= 1'b1;
            end
          end
          CMD: begin
            o_cmd <= i_byte;
            sum   <= i_byte;
            state <= LEN;
          end
          LEN: begin
            o_len <= i_byte;
            sum   <= sum + i_byte;
            if (i_byte > MAX_L) begin
              o_frame_done <= 1'b1;
              o_frame_ok   <= 1'b0;
              o_err_code   <= 2'd1;
              o_busy       <= 1'b0;
              state        <= HUNT;
            end else if (i_byte == 8'd0) begin
              state <= CHK;
            end else begin
              idx   <= '0;
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            o_pl_valid <= 1'b1;
            o_pl_data  <= i_byte;
            o_pl_idx   <= idx;
            sum        <= sum + i_byte;
            idx        <= idx + 8'd1;
            if (idx == o_len - 8'd1) state <= CHK;
          end
          CHK: begin
            o_frame_done <= 1'b1;
            o_frame_ok   <= (i_byte == sum);
            o_err_code   <= (i_byte == sum) ? 2'd0 : 2'd2;
            o_busy       <= 1'b0;
            state        <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end else if (state != HUNT) begin
        if (gap == GAP_TC) begin
          gap          <= '0;
          o_frame_done <= 1'b1;
          o_frame_ok   <= 1'b0;
          o_err_code   <= 2'd3;
          o_busy       <= 1'b0;
          state        <= HUNT;
        end else begin
          gap <= gap + 20'd1;
        end
      end
    end
  end

endmodule
